vivo_pop_packer: RTL and testbench
==================================

# vivo_pop_packer

Consumer-side adapter for the variable-output pop interface of the striped VIVO FIFO. It drives the FIFO's requested element count and accepts the returned bundles. It packs the elements in order into fixed words of WORD_ELEMS elements and presents them on a valid/ready output stream. A flush input emits a partially filled word, so it can be placed directly after a VIVO FIFO instance ahead of fixed-width consumers.

## Interface
- ELEM_WIDTH, 8, bits per element (must match the FIFO).
- OUT_ELEMS_MAX, 4, max elements per FIFO pop bundle (must match the FIFO).
- WORD_ELEMS, 8, elements per output word; must be ≥1 and need not be a multiple of OUT_ELEMS_MAX.

Ports (PW = $clog2(OUT_ELEMS_MAX+1), MW = $clog2(WORD_ELEMS+1)):
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assertion, active-low.
- pop_valid  in  1  FIFO's registered bundle valid.
- pop_ready  out  1  bundle accepted; connects to the FIFO's out_ready.
- pop_data  in  OUT_ELEMS_MAX*ELEM_WIDTH  bundle data, element 0 in the low ELEM_WIDTH bits.
- pop_num_elems  in  PW  element count of the presented bundle.
- pop_req_elems  out  PW  elements requested; connects to the FIFO's out_req_elems.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts the word.
- m_data  out  WORD_ELEMS*ELEM_WIDTH  packed word, oldest element at index 0; unused elements are 0.
- m_num_elems  out  MW  valid elements in m_data (WORD_ELEMS, or fewer for a flushed word).
- flush  in  1  single-cycle pulse requesting emission of the partial word.

## Operation
- State:
  - acc: WORD_ELEMS elements.
  - fill: 0..WORD_ELEMS.
  - flush_pend flag.
  - output register: m_valid, m_data, m_num_elems.
- Request (combinational from registers only): pop_req_elems = flush_pend ? 0 : min(OUT_ELEMS_MAX, WORD_ELEMS − fill).
- Acceptance: pop_ready = pop_valid && !flush_pend && pop_num_elems != 0 && pop_num_elems == pop_req_elems.
  - The FIFO advances its pointers by the current request, so a stale bundle (count ≠ current request) is never accepted.
  - The FIFO re-forms the bundle on the following cycles.
- On accept: acc[fill+k] ← pop_data[k] for k < pop_num_elems; fill ← fill + pop_num_elems. Width: MW-bit sum, never exceeds WORD_ELEMS.
- Transfer: xfer = (fill == WORD_ELEMS || (flush_pend && fill != 0)) && (!m_valid || m_ready).
  - On xfer: m_data ← acc, with elements ≥ fill zeroed.
  - m_num_elems ← fill; m_valid ← 1; fill ← 0; flush_pend ← 0.
- Output handshake:
  - m_valid && m_ready without xfer clears m_valid.
  - With xfer, the register reloads back-to-back.
  - m_data and m_num_elems stay stable while m_valid && !m_ready.
- Flush:
  - flush sets flush_pend.
  - If fill == 0 when flush_pend is set, flush_pend clears the next cycle with no word emitted.
  - A flush while flush_pend is already set has no additional effect.
- Accept and xfer are mutually exclusive by construction:
  - fill == WORD_ELEMS forces req = 0.
  - flush_pend blocks pop_ready.
- Elements left in the FIFO below the current request are not fetched; this is the user's responsibility.

## Timing
- Reset (rst_n low, asynchronous): fill = 0, flush_pend = 0, m_valid = 0, m_data = 0, m_num_elems = 0.
  - Hence pop_req_elems = min(OUT_ELEMS_MAX, WORD_ELEMS) and pop_ready = 0 during reset.
  - Reset mid-word discards acc contents.
- The FIFO presents a bundle 1 cycle after a satisfiable request.
  - It drops valid the cycle after acceptance and re-presents 1 cycle later.
  - Peak rate is therefore one bundle per 2 cycles.
- Fill-to-output: m_valid rises 1 cycle after the edge at which fill reaches WORD_ELEMS, provided the output register is free or draining.
- Flush-to-output: m_valid rises 2 cycles after the flush pulse (1 cycle to set flush_pend, 1 cycle for xfer).
- With m_ready held low, at most one full word is in m_data and one in acc; pop_req_elems = 0 until the xfer.

## Test plan
- Streaming packing (defaults; FIFO holds 0x01..0x08):
  - Requests 4, then 4.
  - m_data elements 0..7 = 0x01..0x08, m_num_elems = 8.
  - m_valid rises 5 cycles after reset release.
- Non-multiple word (WORD_ELEMS = 6; FIFO holds 0x10..0x1B):
  - pop_req_elems sequence 4, 2, 4, 2.
  - Two words 0x10..0x15 and 0x16..0x1B, each m_num_elems = 6.
- Backpressure (m_ready = 0 while 16 elements are consumed):
  - The first word stays held and stable; fill = 8; pop_req_elems = 0.
  - Raising m_ready for 1 cycle loads word 2 on the next edge.
  - No element is lost or duplicated.
- Partial flush (FIFO holds 4 elements 0xA0..0xA3):
  - After accept, pulse flush.
  - m_num_elems = 4, m_data elements 0..3 = 0xA0..0xA3, elements 4..7 = 0.
  - pop_req_elems = 0 while flush_pend is set.
- Stale bundle (flush asserted in the cycle pop_valid rises with count 4):
  - pop_ready stays 0 and the FIFO count is unchanged.
  - After flush_pend clears, the bundle is re-requested and accepted intact.
  - A flush with fill = 0 emits nothing.
- Reset mid-word (fill = 4, m_valid = 1; assert rst_n low asynchronously):
  - m_valid, m_num_elems, and m_data go to 0 immediately; pop_req_elems = 4.
  - After release, normal packing resumes from fill = 0.

Source files
------------

// File: rtl/vivo_pop_packer.sv
// Packs variable-size bundles from a VIVO FIFO pop port into fixed WORD_ELEMS-element words
// on a valid/ready stream; a flush pulse emits a partially filled word.
module vivo_pop_packer #(
    parameter int ELEM_WIDTH    = 8,
    parameter int OUT_ELEMS_MAX = 4,
    parameter int WORD_ELEMS    = 8,
    localparam int PW = $clog2(OUT_ELEMS_MAX + 1),
    localparam int MW = $clog2(WORD_ELEMS + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             pop_valid,
    output logic                             pop_ready,
    input  logic [OUT_ELEMS_MAX*ELEM_WIDTH-1:0] pop_data,
    input  logic [PW-1:0]                    pop_num_elems,
    output logic [PW-1:0]                    pop_req_elems,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [WORD_ELEMS*ELEM_WIDTH-1:0] m_data,
    output logic [MW-1:0]                    m_num_elems,
    input  logic                             flush
);

    localparam int SW = ((MW > PW) ? MW : PW) + 1;
    localparam logic [MW-1:0] FULL = MW'(WORD_ELEMS);

    logic [ELEM_WIDTH-1:0]            acc_reg  [WORD_ELEMS];
    logic [ELEM_WIDTH-1:0]            acc_next [WORD_ELEMS];
    logic [MW-1:0]                    fill_reg, fill_next;
    logic                             flush_pend_reg, flush_pend_next;
    logic                             m_valid_reg, m_valid_next;
    logic [WORD_ELEMS*ELEM_WIDTH-1:0] m_data_reg, m_data_next;
    logic [MW-1:0]                    m_num_reg, m_num_next;
    logic [WORD_ELEMS*ELEM_WIDTH-1:0] word_masked;
    logic [SW-1:0]                    room;
    logic [PW-1:0]                    req;
    logic                             accept;
    logic                             xfer;

    // Request is a pure function of registered state so the FIFO sees a stable count.
    always_comb begin
        room = SW'(FULL) - SW'(fill_reg);
        if (flush_pend_reg) begin
            req = '0;
        end else if (room > SW'(OUT_ELEMS_MAX)) begin
            req = PW'(OUT_ELEMS_MAX);
        end else begin
            req = PW'(room);
        end
    end

    // A bundle formed for an older request is stale and must not be taken.
    assign accept = rst_n && pop_valid && !flush_pend_reg
                    && (pop_num_elems != '0) && (pop_num_elems == req);
    assign xfer   = ((fill_reg == FULL) || (flush_pend_reg && (fill_reg != '0)))
                    && (!m_valid_reg || m_ready);

    assign pop_ready     = accept;
    assign pop_req_elems = req;
    assign m_valid       = m_valid_reg;
    assign m_data        = m_data_reg;
    assign m_num_elems   = m_num_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WORD_ELEMS; gi++) begin : g_slot
            assign word_masked[gi*ELEM_WIDTH +: ELEM_WIDTH] =
                (gi < int'(fill_reg)) ? acc_reg[gi] : '0;
        end
    endgenerate

    always_comb begin
        for (int s = 0; s < WORD_ELEMS; s++) begin
            acc_next[s] = acc_reg[s];
            for (int k = 0; k < OUT_ELEMS_MAX; k++) begin
                if (accept && (k < int'(pop_num_elems)) && (int'(fill_reg) + k == s)) begin
                    acc_next[s] = pop_data[k*ELEM_WIDTH +: ELEM_WIDTH];
                end
            end
        end
    end

    always_comb begin
        fill_next       = fill_reg;
        flush_pend_next = flush_pend_reg;
        m_valid_next    = m_valid_reg;
        m_data_next     = m_data_reg;
        m_num_next      = m_num_reg;

        if (accept) begin
            fill_next = fill_reg + MW'(pop_num_elems);
        end

        // An empty accumulator makes a pending flush a no-op.
        if (flush_pend_reg) begin
            if (fill_reg == '0) begin
                flush_pend_next = 1'b0;
            end
        end else if (flush) begin
            flush_pend_next = 1'b1;
        end

        if (m_valid_reg && m_ready) begin
            m_valid_next = 1'b0;
        end

        if (xfer) begin
            m_valid_next    = 1'b1;
            m_data_next     = word_masked;
            m_num_next      = fill_reg;
            fill_next       = '0;
            flush_pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < WORD_ELEMS; s++) begin
                acc_reg[s] <= '0;
            end
            fill_reg       <= '0;
            flush_pend_reg <= 1'b0;
            m_valid_reg    <= 1'b0;
            m_data_reg     <= '0;
            m_num_reg      <= '0;
        end else begin
            for (int s = 0; s < WORD_ELEMS; s++) begin
                acc_reg[s] <= acc_next[s];
            end
            fill_reg       <= fill_next;
            flush_pend_reg <= flush_pend_next;
            m_valid_reg    <= m_valid_next;
            m_data_reg     <= m_data_next;
            m_num_reg      <= m_num_next;
        end
    end

endmodule

// File: tb/tb_vivo_pop_packer.sv
// Bench for vivo_pop_packer: a queue-based VIVO FIFO model feeds two instances (8- and 6-element
// words); captured output words are compared against the element sequences loaded into the model.
module tb_vivo_pop_packer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        pv0, pr0, mv0, mr0, fl0;
    logic [31:0] pd0;
    logic [2:0]  pn0, preq0;
    logic [63:0] md0;
    logic [3:0]  mn0;

    logic        pv1, pr1, mv1, mr1, fl1;
    logic [31:0] pd1;
    logic [2:0]  pn1, preq1;
    logic [47:0] md1;
    logic [2:0]  mn1;

    vivo_pop_packer #(.ELEM_WIDTH(8), .OUT_ELEMS_MAX(4), .WORD_ELEMS(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .pop_valid(pv0), .pop_ready(pr0), .pop_data(pd0),
        .pop_num_elems(pn0), .pop_req_elems(preq0), .m_valid(mv0), .m_ready(mr0),
        .m_data(md0), .m_num_elems(mn0), .flush(fl0)
    );

    vivo_pop_packer #(.ELEM_WIDTH(8), .OUT_ELEMS_MAX(4), .WORD_ELEMS(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .pop_valid(pv1), .pop_ready(pr1), .pop_data(pd1),
        .pop_num_elems(pn1), .pop_req_elems(preq1), .m_valid(mv1), .m_ready(mr1),
        .m_data(md1), .m_num_elems(mn1), .flush(fl1)
    );

    logic [7:0]  fmem [2][512];
    int          fhead [2];
    int          ftail [2];
    logic [63:0] cap_d0 [$];
    logic [3:0]  cap_n0 [$];
    logic [47:0] cap_d1 [$];
    logic [2:0]  cap_n1 [$];
    int          req_log1 [$];
    int          errors = 0;
    int          checks = 0;

    task automatic load(input int ch, input logic [7:0] v);
        fmem[ch][ftail[ch]] = v;
        ftail[ch]++;
    endtask

    // FIFO model: pops the accepted count, else presents a bundle if the request is satisfiable.
    task automatic fifo_step(input int ch, input bit acc, input int num, input int req,
                             output logic v, output logic [31:0] d, output logic [2:0] n);
        v = 1'b0;
        d = '0;
        n = '0;
        if (acc) begin
            fhead[ch] += num;
        end else if (req != 0 && (ftail[ch] - fhead[ch]) >= req) begin
            v = 1'b1;
            n = 3'(req);
            for (int k = 0; k < req; k++) d[k*8 +: 8] = fmem[ch][fhead[ch] + k];
        end
    endtask

    task automatic tick();
        bit a0, a1;
        int r0, r1, n0, n1;
        @(negedge clk);
        a0 = pv0 && pr0;
        a1 = pv1 && pr1;
        r0 = int'(preq0);
        r1 = int'(preq1);
        n0 = int'(pn0);
        n1 = int'(pn1);
        if (a1) req_log1.push_back(n1);
        if (mv0 && mr0) begin
            cap_d0.push_back(md0);
            cap_n0.push_back(mn0);
        end
        if (mv1 && mr1) begin
            cap_d1.push_back(md1);
            cap_n1.push_back(mn1);
        end
        @(posedge clk);
        #1;
        fl0 = 1'b0;
        fl1 = 1'b0;
        if (rst_n) begin
            fifo_step(0, a0, n0, r0, pv0, pd0, pn0);
            fifo_step(1, a1, n1, r1, pv1, pd1, pn1);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        pv0 = 1'b0; pd0 = '0; pn0 = '0; fl0 = 1'b0; mr0 = 1'b1;
        pv1 = 1'b0; pd1 = '0; pn1 = '0; fl1 = 1'b0; mr1 = 1'b1;
        fhead[0] = 0; fhead[1] = 0; ftail[0] = 0; ftail[1] = 0;
        cap_d0.delete(); cap_n0.delete(); cap_d1.delete(); cap_n1.delete();
        req_log1.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        pv0 = 1'b1; pn0 = 3'd4; pd0 = 32'hDEADBEEF; mr0 = 1'b1; fl0 = 1'b0;
        pv1 = 1'b0; pn1 = '0; pd1 = '0; mr1 = 1'b1; fl1 = 1'b0;
        #2;
        checks++; if (mv0 !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", mv0); end
        checks++; if (md0 !== 64'h0) begin errors++; $display("FAIL reset_m_data got %h exp 0", md0); end
        checks++; if (mn0 !== 4'd0) begin errors++; $display("FAIL reset_m_num got %0d exp 0", mn0); end
        checks++; if (preq0 !== 3'd4) begin errors++; $display("FAIL reset_req got %0d exp 4", preq0); end
        checks++; if (pr0 !== 1'b0) begin errors++; $display("FAIL reset_pop_ready got %b exp 0", pr0); end
        checks++; if (preq1 !== 3'd4) begin errors++; $display("FAIL reset_req_w6 got %0d exp 4", preq1); end
    endtask

    task automatic test_stream();
        logic [63:0] exp_w;
        apply_reset();
        exp_w = '0;
        for (int i = 0; i < 8; i++) begin
            load(0, 8'(i + 1));
            exp_w[i*8 +: 8] = 8'(i + 1);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 4) begin
                checks++; if (mv0 !== 1'b0) begin errors++; $display("FAIL stream_early_valid got %b exp 0", mv0); end
            end
            if (c == 5) begin
                checks++; if (mv0 !== 1'b1) begin errors++; $display("FAIL stream_valid_at_5 got %b exp 1", mv0); end
            end
        end
        checks++;
        if (cap_d0.size() != 1) begin
            errors++; $display("FAIL stream_word_count got %0d exp 1", cap_d0.size());
        end else begin
            checks++; if (cap_d0[0] !== exp_w) begin errors++; $display("FAIL stream_data got %h exp %h", cap_d0[0], exp_w); end
            checks++; if (cap_n0[0] !== 4'd8) begin errors++; $display("FAIL stream_num got %0d exp 8", cap_n0[0]); end
        end
        $display("stream: words=%0d", cap_d0.size());
    endtask

    task automatic test_non_multiple();
        int          exp_req [4] = '{4, 2, 4, 2};
        logic [47:0] exp_w [2];
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            load(1, 8'(8'h10 + i));
            exp_w[i / 6][(i % 6)*8 +: 8] = 8'(8'h10 + i);
        end
        repeat (16) tick();
        checks++;
        if (req_log1.size() != 4) begin
            errors++; $display("FAIL w6_req_count got %0d exp 4", req_log1.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (req_log1[i] != exp_req[i]) begin errors++; $display("FAIL w6_req[%0d] got %0d exp %0d", i, req_log1[i], exp_req[i]); end
            end
        end
        checks++;
        if (cap_d1.size() != 2) begin
            errors++; $display("FAIL w6_word_count got %0d exp 2", cap_d1.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++; if (cap_d1[i] !== exp_w[i]) begin errors++; $display("FAIL w6_data[%0d] got %h exp %h", i, cap_d1[i], exp_w[i]); end
                checks++; if (cap_n1[i] !== 3'd6) begin errors++; $display("FAIL w6_num[%0d] got %0d exp 6", i, cap_n1[i]); end
            end
        end
        $display("non_multiple: words=%0d requests=%0d", cap_d1.size(), req_log1.size());
    endtask

    task automatic test_backpressure();
        logic [63:0] w [2];
        int          unstable;
        apply_reset();
        mr0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            load(0, v);
            w[i / 8][(i % 8)*8 +: 8] = v;
        end
        unstable = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c >= 5 && (mv0 !== 1'b1 || md0 !== w[0])) unstable++;
        end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_held_word unstable_cycles got %0d exp 0", unstable); end
        checks++; if (mn0 !== 4'd8) begin errors++; $display("FAIL bp_held_num got %0d exp 8", mn0); end
        checks++; if (preq0 !== 3'd0) begin errors++; $display("FAIL bp_req got %0d exp 0", preq0); end
        checks++; if (fhead[0] != 16) begin errors++; $display("FAIL bp_consumed got %0d exp 16", fhead[0]); end
        mr0 = 1'b1;
        tick();
        mr0 = 1'b0;
        checks++; if (mv0 !== 1'b1 || md0 !== w[1]) begin errors++; $display("FAIL bp_word2_load got v=%b %h exp v=1 %h", mv0, md0, w[1]); end
        mr0 = 1'b1;
        repeat (3) tick();
        checks++;
        if (cap_d0.size() != 2) begin
            errors++; $display("FAIL bp_word_count got %0d exp 2", cap_d0.size());
        end else begin
            checks++; if (cap_d0[0] !== w[0] || cap_d0[1] !== w[1]) begin errors++; $display("FAIL bp_words got %h %h exp %h %h", cap_d0[0], cap_d0[1], w[0], w[1]); end
        end
        $display("backpressure: words=%0d", cap_d0.size());
    endtask

    task automatic test_partial_flush();
        logic [63:0] exp_w;
        apply_reset();
        exp_w = '0;
        for (int i = 0; i < 4; i++) begin
            load(0, 8'(8'hA0 + i));
            exp_w[i*8 +: 8] = 8'(8'hA0 + i);
        end
        repeat (2) tick();
        fl0 = 1'b1;
        tick();
        checks++; if (preq0 !== 3'd0) begin errors++; $display("FAIL flush_req_pending got %0d exp 0", preq0); end
        checks++; if (mv0 !== 1'b0) begin errors++; $display("FAIL flush_early_valid got %b exp 0", mv0); end
        tick();
        checks++; if (mv0 !== 1'b1) begin errors++; $display("FAIL flush_valid got %b exp 1", mv0); end
        checks++; if (mn0 !== 4'd4) begin errors++; $display("FAIL flush_num got %0d exp 4", mn0); end
        checks++; if (md0 !== exp_w) begin errors++; $display("FAIL flush_data got %h exp %h", md0, exp_w); end
        checks++; if (preq0 !== 3'd4) begin errors++; $display("FAIL flush_req_after got %0d exp 4", preq0); end
        $display("partial_flush: num=%0d data=%h", mn0, md0);
    endtask

    task automatic test_stale();
        logic [63:0] exp_w;
        apply_reset();
        exp_w = '0;
        for (int i = 0; i < 8; i++) begin
            load(0, 8'(8'h30 + i));
            exp_w[i*8 +: 8] = 8'(8'h30 + i);
        end
        fl0 = 1'b1;
        tick();
        checks++; if (pv0 !== 1'b1 || pr0 !== 1'b0) begin errors++; $display("FAIL stale_ready got valid=%b ready=%b exp valid=1 ready=0", pv0, pr0); end
        tick();
        checks++; if (ftail[0] - fhead[0] != 8) begin errors++; $display("FAIL stale_fifo_count got %0d exp 8", ftail[0] - fhead[0]); end
        checks++; if (mv0 !== 1'b0) begin errors++; $display("FAIL stale_empty_flush_word got %b exp 0", mv0); end
        checks++; if (preq0 !== 3'd4) begin errors++; $display("FAIL stale_req_restored got %0d exp 4", preq0); end
        repeat (6) tick();
        checks++;
        if (cap_d0.size() != 1) begin
            errors++; $display("FAIL stale_word_count got %0d exp 1", cap_d0.size());
        end else begin
            checks++; if (cap_d0[0] !== exp_w || cap_n0[0] !== 4'd8) begin errors++; $display("FAIL stale_word got %h n=%0d exp %h n=8", cap_d0[0], cap_n0[0], exp_w); end
        end
        $display("stale: words=%0d", cap_d0.size());
    endtask

    task automatic test_reset_mid();
        logic [63:0] exp_w;
        apply_reset();
        mr0 = 1'b0;
        for (int i = 0; i < 12; i++) load(0, 8'(8'h70 + i));
        repeat (8) tick();
        checks++; if (mv0 !== 1'b1 || fhead[0] != 12) begin errors++; $display("FAIL rmid_setup got valid=%b consumed=%0d exp valid=1 consumed=12", mv0, fhead[0]); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mv0 !== 1'b0 || mn0 !== 4'd0 || md0 !== 64'h0) begin errors++; $display("FAIL rmid_async got v=%b n=%0d d=%h exp all 0", mv0, mn0, md0); end
        checks++; if (preq0 !== 3'd4) begin errors++; $display("FAIL rmid_req got %0d exp 4", preq0); end
        apply_reset();
        exp_w = '0;
        for (int i = 0; i < 8; i++) begin
            load(0, 8'(8'h50 + i));
            exp_w[i*8 +: 8] = 8'(8'h50 + i);
        end
        repeat (8) tick();
        checks++;
        if (cap_d0.size() != 1) begin
            errors++; $display("FAIL rmid_word_count got %0d exp 1", cap_d0.size());
        end else begin
            checks++; if (cap_d0[0] !== exp_w || cap_n0[0] !== 4'd8) begin errors++; $display("FAIL rmid_word got %h n=%0d exp %h n=8", cap_d0[0], cap_n0[0], exp_w); end
        end
        $display("reset_mid: words=%0d", cap_d0.size());
    endtask

    task automatic test_random();
        int         n;
        int         popped;
        int         bad_shape;
        int         bad_elem;
        int         got_total;
        logic [7:0] vals [64];
        apply_reset();
        n = $urandom_range(20, 60);
        for (int i = 0; i < n; i++) begin
            vals[i] = 8'($urandom);
            load(0, vals[i]);
        end
        for (int c = 0; c < 400; c++) begin
            mr0 = 1'($urandom_range(0, 1));
            fl0 = ($urandom_range(0, 15) == 0);
            tick();
        end
        mr0 = 1'b1;
        fl0 = 1'b1;
        tick();
        repeat (10) tick();
        popped = fhead[0];
        bad_shape = 0;
        bad_elem = 0;
        got_total = 0;
        for (int wd = 0; wd < cap_d0.size(); wd++) begin
            int cnt;
            logic [63:0] d;
            cnt = int'(cap_n0[wd]);
            d = cap_d0[wd];
            if (cnt < 1 || cnt > 8) bad_shape++;
            for (int e = 0; e < 8; e++) begin
                if (e >= cnt) begin
                    if (d[e*8 +: 8] !== 8'h00) bad_shape++;
                end else begin
                    if (got_total >= 64 || d[e*8 +: 8] !== vals[got_total]) bad_elem++;
                    got_total++;
                end
            end
        end
        checks++; if (popped < n - 3 || popped > n) begin errors++; $display("FAIL rand_popped got %0d exp %0d..%0d", popped, n - 3, n); end
        checks++; if (got_total != popped) begin errors++; $display("FAIL rand_total got %0d exp %0d", got_total, popped); end
        checks++; if (bad_elem != 0) begin errors++; $display("FAIL rand_order bad_elems got %0d exp 0", bad_elem); end
        checks++; if (bad_shape != 0) begin errors++; $display("FAIL rand_shape bad got %0d exp 0", bad_shape); end
        $display("random: loaded=%0d popped=%0d words=%0d", n, popped, cap_d0.size());
    endtask

    initial begin
        test_reset();
        test_stream();
        test_non_multiple();
        test_backpressure();
        test_partial_flush();
        test_stale();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
